// File: rtl/simple_pkg.sv
// Shared encodings for the SIMPLE pipeline: opcodes, branch conditions,
// memory operations, the flag register layout and the hex display font.
package simple_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SLR = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_OUT = 4'd13;

  localparam logic [2:0] COND_EQ = 3'd0;
  localparam logic [2:0] COND_LT = 3'd1;
  localparam logic [2:0] COND_LE = 3'd2;
  localparam logic [2:0] COND_NE = 3'd3;
  localparam logic [2:0] COND_AL = 3'd4;

  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_RD   = 2'd1;
  localparam logic [1:0] MEM_WR   = 2'd2;

  typedef struct packed {
    logic s;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic op_sets_flags(input logic [3:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_MOV,
      OP_SLL, OP_SLR, OP_SRL, OP_SRA: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic cond_met(input logic [2:0] cond, input flags_t f);
    logic r;
    case (cond)
      COND_EQ: r = f.z;
      COND_LT: r = f.s ^ f.v;
      COND_LE: r = f.z | (f.s ^ f.v);
      COND_NE: r = ~f.z;
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Segment order is a..g at [7:1], decimal point at [0] (always off).
  function automatic logic [7:0] hex7seg(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'h0: r = 8'hFC;  4'h1: r = 8'h60;  4'h2: r = 8'hDA;  4'h3: r = 8'hF2;
      4'h4: r = 8'h66;  4'h5: r = 8'hB6;  4'h6: r = 8'hBE;  4'h7: r = 8'hE0;
      4'h8: r = 8'hFE;  4'h9: r = 8'hF6;  4'hA: r = 8'hEE;  4'hB: r = 8'h3E;
      4'hC: r = 8'h1A;  4'hD: r = 8'h7A;  4'hE: r = 8'h9E;  default: r = 8'h8E;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU of the execute stage: result plus the S/Z/C/V flags
// that this operation would produce.
module exec_alu
  import simple_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   op_i,
  output logic [W-1:0] result_o,
  output logic         s_o,
  output logic         z_o,
  output logic         c_o,
  output logic         v_o
);

  localparam int SH_W  = $clog2(W);
  localparam int SH_W1 = SH_W + 1;

  logic [W:0]      sum;
  logic [W:0]      diff;
  logic [SH_W-1:0] sh;
  logic [SH_W:0]   inv_sh;
  logic [W-1:0]    spill_l;
  logic [W-1:0]    spill_r;

  assign sum    = {1'b0, a_i} + {1'b0, b_i};
  assign diff   = {1'b0, a_i} - {1'b0, b_i};
  assign sh     = b_i[SH_W-1:0];
  assign inv_sh = SH_W1'(W) - {1'b0, sh};
  // Bits pushed out by a shift of sh; a zero shift spills nothing, so C = 0.
  assign spill_l = a_i >> inv_sh;
  assign spill_r = a_i << inv_sh;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    result_o = a_i;
    c_o      = 1'b0;
    v_o      = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum[W-1:0];
        c_o      = sum[W];
        v_o      = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      OP_SUB, OP_CMP: begin
        result_o = diff[W-1:0];
        c_o      = diff[W];
        v_o      = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_MOV: result_o = b_i;
      OP_SLL: begin
        result_o = a_i << sh;
        c_o      = spill_l[0];
      end
      OP_SLR: begin
        result_o = (a_i << sh) | spill_l;
        c_o      = spill_l[0];
      end
      OP_SRL: begin
        result_o = a_i >> sh;
        c_o      = spill_r[W-1];
      end
      OP_SRA: begin
        result_o = $unsigned($signed(a_i) >>> sh);
        c_o      = spill_r[W-1];
      end
      default: result_o = a_i;
    endcase
  end

  assign s_o = result_o[W-1];
  assign z_o = (result_o == '0);

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU, flag register, branch resolution, memory enables,
// single-register ready/valid output and a multiplexed hex display.
module exec_stage
  import simple_pkg::*;
#(
  parameter int W        = 16,
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [3:0]         in_opcode,
  input  logic               in_wreg,
  input  logic [2:0]         in_waddr,
  input  logic [1:0]         in_mem_op,
  input  logic [W-1:0]       in_addr,
  input  logic [W-1:0]       in_sdata,
  input  logic               in_isbranch,
  input  logic [2:0]         in_cond,
  input  logic [W-1:0]       in_pc1,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_result,
  output logic [W-1:0]       out_addr,
  output logic [W-1:0]       out_sdata,
  output logic               out_wreg,
  output logic [2:0]         out_waddr,
  output logic               out_rd_en,
  output logic               out_wr_en,
  output logic               redirect,
  output logic [W-1:0]       redirect_pc,
  output logic [7:0]         seg,
  output logic [NDIGITS-1:0] dig_sel
);

  localparam int DISP_W = 4 * NDIGITS;
  localparam int IDX_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int PS_W   = $clog2(SCAN_DIV);

  logic               out_valid_q, valid_d;
  logic [W-1:0]       result_q, addr_q, sdata_q, redirect_pc_q;
  logic               wreg_q, rd_en_q, wr_en_q, redirect_q, redirect_d;
  logic [2:0]         waddr_q;
  flags_t             flags_q, flags_d;
  logic [DISP_W-1:0]  disp_q, disp_d, disp_shift;
  logic [PS_W-1:0]    ps_q, ps_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               accept, rd_d, wr_d;
  logic [W-1:0]       alu_result;
  logic               alu_s, alu_z, alu_c, alu_v;

  exec_alu #(.W(W)) u_alu (
    .a_i      (in_a),
    .b_i      (in_b),
    .op_i     (in_opcode),
    .result_o (alu_result),
    .s_o      (alu_s),
    .z_o      (alu_z),
    .c_o      (alu_c),
    .v_o      (alu_v)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Branches read flags_q, i.e. the flags as they stood before this instruction.
  assign redirect_d = accept && in_isbranch && cond_met(in_cond, flags_q);

  always_comb begin
    valid_d = out_valid_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;

    flags_d = flags_q;
    if (accept && op_sets_flags(in_opcode))
      flags_d = '{s: alu_s, z: alu_z, c: alu_c, v: alu_v};

    disp_d = disp_q;
    if (accept && (in_opcode == OP_OUT))
      disp_d = DISP_W'(in_a);

    rd_d = 1'b0;
    wr_d = 1'b0;
    case (in_mem_op)
      MEM_RD:   rd_d = 1'b1;
      MEM_WR:   wr_d = 1'b1;
      MEM_NONE: ;
      default:  ;
    endcase

    ps_d  = ps_q + 1'b1;
    idx_d = idx_q;
    if (ps_q == PS_W'(SCAN_DIV - 1)) begin
      ps_d  = '0;
      idx_d = (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      result_q      <= '0;
      addr_q        <= '0;
      sdata_q       <= '0;
      wreg_q        <= 1'b0;
      waddr_q       <= '0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flags_q       <= '0;
      disp_q        <= '0;
      ps_q          <= '0;
      idx_q         <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the same pre-edge values.
      out_valid_q <= valid_d;
      redirect_q  <= redirect_d;
      flags_q     <= flags_d;
      disp_q      <= disp_d;
      ps_q        <= ps_d;
      idx_q       <= idx_d;
      if (accept) begin
        result_q <= alu_result;
        addr_q   <= in_addr;
        sdata_q  <= in_sdata;
        wreg_q   <= in_wreg && (in_opcode != OP_CMP);
        waddr_q  <= in_waddr;
        rd_en_q  <= rd_d;
        wr_en_q  <= wr_d;
      end
      if (redirect_d)
        redirect_pc_q <= in_pc1 + in_sdata;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = result_q;
  assign out_addr    = addr_q;
  assign out_sdata   = sdata_q;
  assign out_wreg    = wreg_q;
  assign out_waddr   = waddr_q;
  assign out_rd_en   = rd_en_q;
  assign out_wr_en   = wr_en_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

  // Digit 0 shows the least-significant nibble.
  assign disp_shift = disp_q >> {idx_q, 2'b00};
  assign seg        = hex7seg(disp_shift[3:0]);
  assign dig_sel    = NDIGITS'(1) << idx_q;

endmodule
